rotate_scan_ctrl: RTL and testbench

Frame sequencer that drives the image-rotation coordinate engine from the initiator side of its start/done handshake. It raster-scans every destination pixel of an IMAGE_SIZE×IMAGE_SIZE frame and issues one rotation request per pixel. It fetches the resulting source pixel from a 1-cycle-latency image memory, or substitutes BG_PIXEL when the source falls outside the image, and streams the rotated frame out under valid/ready flow control.

---
 rtl/rotate_scan_ctrl_if.sv | 47 ++++
 rtl/rotate_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_rotate_scan_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rotate_scan_ctrl_if.sv
// Signal bundle between the frame sequencer and its environment: rotation
// engine request/response, image memory read port and the output pixel stream.
interface rotate_scan_ctrl_if #(
  parameter int IMAGE_COOR_BIT = 7,
  parameter int ANG_WIDTH      = 9,
  parameter int ADDR_BIT       = 12,
  parameter int PIX_WIDTH      = 8
);
  logic                          o_rot_start;
  logic [IMAGE_COOR_BIT-1:0]     o_rot_H;
  logic [IMAGE_COOR_BIT-1:0]     o_rot_V;
  logic signed [ANG_WIDTH-1:0]   o_rot_angle;
  logic                          i_rot_done;
  logic [IMAGE_COOR_BIT-1:0]     i_rot_H;
  logic [IMAGE_COOR_BIT-1:0]     i_rot_V;
  logic                          i_rot_outOfRange;

  logic                          o_mem_rd_en;
  logic [ADDR_BIT-1:0]           o_mem_addr;
  logic [PIX_WIDTH-1:0]          i_mem_rdata;

  // Pixel stream: a beat transfers on a cycle where o_pix_valid and i_pix_ready
  // are both high; once raised, valid and its payload hold until that transfer.
  logic                          o_pix_valid;
  logic                          i_pix_ready;
  logic [PIX_WIDTH-1:0]          o_pix_data;
  logic [IMAGE_COOR_BIT-1:0]     o_pix_H;
  logic [IMAGE_COOR_BIT-1:0]     o_pix_V;

  modport master (
    output o_rot_start, o_rot_H, o_rot_V, o_rot_angle,
    input  i_rot_done, i_rot_H, i_rot_V, i_rot_outOfRange,
    output o_mem_rd_en, o_mem_addr,
    input  i_mem_rdata,
    output o_pix_valid, o_pix_data, o_pix_H, o_pix_V,
    input  i_pix_ready
  );

  modport slave (
    input  o_rot_start, o_rot_H, o_rot_V, o_rot_angle,
    output i_rot_done, i_rot_H, i_rot_V, i_rot_outOfRange,
    input  o_mem_rd_en, o_mem_addr,
    output i_mem_rdata,
    input  o_pix_valid, o_pix_data, o_pix_H, o_pix_V,
    output i_pix_ready
  );
endinterface

// File: rtl/rotate_scan_ctrl.sv
// Raster-scans a square frame, requests one rotation per destination pixel,
// fetches the source pixel (or background) and streams the rotated frame out.
module rotate_scan_ctrl #(
  parameter int                   IMAGE_SIZE     = 60,
  parameter int                   IMAGE_COOR_BIT = 7,
  parameter int                   ANG_WIDTH      = 9,
  parameter int                   ADDR_BIT       = 12,
  parameter int                   PIX_WIDTH      = 8,
  parameter logic [PIX_WIDTH-1:0] BG_PIXEL       = '0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_frame_start,
  input  logic signed [ANG_WIDTH-1:0] i_angle,
  output logic                        o_busy,
  output logic                        o_frame_done,
  output logic [2:0]                  o_dbg_state,
  rotate_scan_ctrl_if.master          bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_ROT = 3'd2,
    S_MEM_RD   = 3'd3,
    S_MEM_CAP  = 3'd4,
    S_OUT      = 3'd5
  } state_e;

  localparam logic [IMAGE_COOR_BIT-1:0] SIZE_C   = IMAGE_COOR_BIT'(IMAGE_SIZE);
  localparam logic [IMAGE_COOR_BIT-1:0] LAST_C   = IMAGE_COOR_BIT'(IMAGE_SIZE - 1);
  localparam logic [ADDR_BIT-1:0]       STRIDE_C = ADDR_BIT'(IMAGE_SIZE);

  state_e                      state_q, state_d;
  logic [IMAGE_COOR_BIT-1:0]   h_q, h_d;
  logic [IMAGE_COOR_BIT-1:0]   v_q, v_d;
  logic signed [ANG_WIDTH-1:0] angle_q, angle_d;
  logic [ADDR_BIT-1:0]         addr_q, addr_d;
  logic [PIX_WIDTH-1:0]        pix_q, pix_d;
  logic                        frame_done_q, frame_done_d;
  logic                        src_oor;

  // The engine's own flag is not trusted alone: coordinates past the frame edge
  // would otherwise alias into a neighbouring row of the memory.
  assign src_oor = bus.i_rot_outOfRange || (bus.i_rot_H >= SIZE_C) || (bus.i_rot_V >= SIZE_C);

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    v_d          = v_q;
    angle_d      = angle_q;
    addr_d       = addr_q;
    pix_d        = pix_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_frame_start) begin
          angle_d = i_angle;
          h_d     = '0;
          v_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT_ROT;
      S_WAIT_ROT: begin
        if (bus.i_rot_done) begin
          addr_d = ADDR_BIT'(bus.i_rot_V) * STRIDE_C + ADDR_BIT'(bus.i_rot_H);
          if (src_oor) begin
            pix_d   = BG_PIXEL;
            state_d = S_OUT;
          end else begin
            state_d = S_MEM_RD;
          end
        end
      end
      S_MEM_RD: state_d = S_MEM_CAP;
      S_MEM_CAP: begin
        pix_d   = bus.i_mem_rdata;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.i_pix_ready) begin
          state_d = S_ISSUE;
          if (h_q == LAST_C) begin
            h_d = '0;
            if (v_q == LAST_C) begin
              v_d          = '0;
              frame_done_d = 1'b1;
              state_d      = S_IDLE;
            end else begin
              v_d = v_q + 1'b1;
            end
          end else begin
            h_d = h_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      h_q          <= '0;
      v_q          <= '0;
      angle_q      <= '0;
      addr_q       <= '0;
      pix_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      angle_q      <= angle_d;
      addr_q       <= addr_d;
      pix_q        <= pix_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Request and output coordinates share the counters: both name the
  // destination pixel currently being produced.
  assign bus.o_rot_start = (state_q == S_ISSUE);
  assign bus.o_rot_H     = h_q;
  assign bus.o_rot_V     = v_q;
  assign bus.o_rot_angle = angle_q;
  assign bus.o_mem_rd_en = (state_q == S_MEM_RD);
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_pix_valid = (state_q == S_OUT);
  assign bus.o_pix_data  = pix_q;
  assign bus.o_pix_H     = h_q;
  assign bus.o_pix_V     = v_q;
  assign o_busy          = (state_q != S_IDLE);
  assign o_frame_done    = frame_done_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_rotate_scan_ctrl.sv
// Scoreboard bench for rotate_scan_ctrl: rotator/memory/ready models drive the
// DUT, a reference model predicts every output pixel and its timing.
module tb_rotate_scan_ctrl;
  localparam int S = 4;
  localparam int C = 7;
  localparam int A = 9;
  localparam int AB = 12;
  localparam int P = 8;
  localparam int W = P + 2 * C;
  localparam logic [P-1:0] BG = '0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic                frame_start;
  logic signed [A-1:0] angle;
  logic                busy, frame_done;
  logic [2:0]          dbg_state;
  rotate_scan_ctrl_if #(.IMAGE_COOR_BIT(C), .ANG_WIDTH(A), .ADDR_BIT(AB), .PIX_WIDTH(P)) bus ();
  rotate_scan_ctrl #(.IMAGE_SIZE(S), .IMAGE_COOR_BIT(C), .ANG_WIDTH(A), .ADDR_BIT(AB),
                     .PIX_WIDTH(P), .BG_PIXEL(BG)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start), .i_angle(angle),
    .o_busy(busy), .o_frame_done(frame_done), .o_dbg_state(dbg_state), .bus(bus));

  // Full-size instance, used only for the address arithmetic corner.
  logic                fs_b;
  logic signed [A-1:0] angle_b;
  logic                busy_b, frame_done_b;
  logic [2:0]          dbg_b;
  rotate_scan_ctrl_if #(.IMAGE_COOR_BIT(C), .ANG_WIDTH(A), .ADDR_BIT(AB), .PIX_WIDTH(P)) busb ();
  rotate_scan_ctrl #(.IMAGE_SIZE(60), .IMAGE_COOR_BIT(C), .ANG_WIDTH(A), .ADDR_BIT(AB),
                     .PIX_WIDTH(P), .BG_PIXEL(BG)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs_b), .i_angle(angle_b),
    .o_busy(busy_b), .o_frame_done(frame_done_b), .o_dbg_state(dbg_b), .bus(busb));

  // ---------------- shared state ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [P-1:0] mem [0:S*S-1];
  int rot_mode, fixed_delay, ready_mode;
  logic signed [A-1:0] exp_angle;
  int done_cyc = 0;
  bit done_oor = 0;
  logic [AB-1:0] exp_addr = '0;
  int pix_count = 0, rd_count = 0, stall_21 = 0, evt_cyc = -10;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return {2'b00, bus.o_rot_start, bus.o_rot_H, bus.o_rot_V, bus.o_rot_angle, bus.o_mem_rd_en,
            bus.o_mem_addr, bus.o_pix_valid, bus.o_pix_data, bus.o_pix_H, bus.o_pix_V,
            busy, frame_done};
  endfunction

  // ---------------- rotation engine model + expectation source ----------------
  initial begin : rot_model
    int k, cnt;
    bit pending, roor, eff;
    logic [C-1:0] req_h, req_v, rh, rv;
    logic [P-1:0] ed;
    k = 0; cnt = 0; pending = 0;
    bus.i_rot_done = 1'b0; bus.i_rot_H = '0; bus.i_rot_V = '0; bus.i_rot_outOfRange = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_rot_done = 1'b0;
      if (rst) begin
        pending = 0;
        k = 0;
      end else begin
        if (!busy) k = 0;
        if (bus.o_rot_start) begin
          check("rot_req_H", bus.o_rot_H, k % S);
          check("rot_req_V", bus.o_rot_V, k / S);
          check("rot_angle", bus.o_rot_angle, exp_angle);
          req_h = bus.o_rot_H;
          req_v = bus.o_rot_V;
          cnt = (fixed_delay != 0) ? fixed_delay : $urandom_range(1, 4);
          pending = 1;
        end else if (pending) begin
          cnt--;
          if (cnt == 0) begin
            pending = 0;
            case (rot_mode)
              0: begin rh = req_h; rv = req_v; roor = 0; end
              1: begin rh = req_h; rv = req_v; roor = 1; end
              2: begin
                rh = C'($urandom_range(0, S + 1));
                rv = C'($urandom_range(0, S + 1));
                roor = ($urandom_range(0, 7) == 0);
              end
              default: begin rh = (k == 5) ? C'(60) : req_h; rv = req_v; roor = 0; end
            endcase
            eff = roor || (int'(rh) >= S) || (int'(rv) >= S);
            ed = eff ? BG : mem[int'(rv) * S + int'(rh)];
            exp_q.push_back({ed, C'(k % S), C'(k / S)});
            done_cyc = cyc;
            done_oor = eff;
            exp_addr = AB'(int'(rv) * S + int'(rh));
            bus.i_rot_done = 1'b1;
            bus.i_rot_H = rh;
            bus.i_rot_V = rv;
            bus.i_rot_outOfRange = roor;
            k++;
          end
        end
      end
    end
  end

  // ---------------- 1-cycle-latency image memory ----------------
  initial begin : mem_model
    bit rd_prev;
    logic [AB-1:0] a_prev;
    rd_prev = 0; a_prev = '0;
    bus.i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.i_mem_rdata = rd_prev ? mem[int'(a_prev) % (S * S)] : P'($urandom);
      rd_prev = bus.o_mem_rd_en;
      a_prev = bus.o_mem_addr;
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin : ready_drv
    int stall;
    stall = 0;
    bus.i_pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!busy) stall = 0;
      case (ready_mode)
        0: bus.i_pix_ready = 1'b1;
        1: bus.i_pix_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (bus.o_pix_valid && bus.o_pix_H == 2 && bus.o_pix_V == 1 && stall < 5) begin
            bus.i_pix_ready = 1'b0;
            stall++;
          end else begin
            bus.i_pix_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit held, prev_valid;
    logic [W-1:0] held_v, got, exp;
    held = 0; prev_valid = 0; held_v = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0; prev_valid = 0; pix_count = 0; evt_cyc = -10;
      end else begin
        got = {bus.o_pix_data, bus.o_pix_H, bus.o_pix_V};
        if (held) begin
          check("stall_valid_held", bus.o_pix_valid, 1);
          check("stall_payload_held", got, held_v);
          check("stall_no_rot_start", bus.o_rot_start, 0);
        end
        if (frame_start && !busy) begin
          evt_cyc = cyc; pix_count = 0; rd_count = 0; stall_21 = 0;
        end
        if (bus.o_rot_start) check("rot_start_cycle", cyc, evt_cyc + 1);
        if (bus.o_mem_rd_en) begin
          rd_count++;
          check("mem_rd_cycle", cyc, done_cyc + 1);
          check("mem_rd_for_oor", done_oor, 0);
          check("mem_addr", bus.o_mem_addr, exp_addr);
        end
        if (bus.o_pix_valid && !prev_valid)
          check("valid_latency", cyc, done_cyc + (done_oor ? 1 : 3));
        if (frame_done) begin
          check("frame_done_cycle", cyc, evt_cyc + 1);
          check("frame_done_busy", busy, 0);
          check("frame_pixel_count", pix_count, S * S);
        end
        if (bus.o_pix_valid && bus.i_pix_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pixel_unexpected: got %0h with no expected pixel queued", got);
          end else begin
            exp = exp_q.pop_front();
            check("pixel", got, exp);
          end
          pix_count++;
          evt_cyc = cyc;
        end
        held = bus.o_pix_valid && !bus.i_pix_ready;
        held_v = got;
        if (held && bus.o_pix_H == 2 && bus.o_pix_V == 1) stall_21++;
        prev_valid = bus.o_pix_valid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_frame(input logic signed [A-1:0] ang);
    bit got;
    @(posedge clk); #1;
    angle = ang;
    exp_angle = ang;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk); #1;
      if (frame_done) got = 1;
    end
    check("frame_completed", got, 1);
    if (got) begin
      @(posedge clk); #1;
      check("frame_done_one_cycle", frame_done, 0);
      check("idle_after_frame", busy, 0);
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    bit got;
    rst = 1'b1; frame_start = 1'b0; angle = '0; exp_angle = '0;
    rot_mode = 0; fixed_delay = 3; ready_mode = 0;
    fs_b = 1'b0; angle_b = '0;
    busb.i_rot_done = 1'b0; busb.i_rot_H = '0; busb.i_rot_V = '0; busb.i_rot_outOfRange = 1'b0;
    busb.i_mem_rdata = '0; busb.i_pix_ready = 1'b0;
    for (int a = 0; a < S * S; a++) mem[a] = P'(a);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs_vec(), 64'd0);
    rst = 1'b0;

    // identity rotator, memory[a]=a, always ready
    run_frame(A'(10));
    check("identity_reads", rd_count, S * S);

    // every request out of range
    rot_mode = 1;
    run_frame(A'(20));
    check("oor_no_reads", rd_count, 0);

    // stall on pixel (2,1)
    rot_mode = 0; ready_mode = 2;
    run_frame(A'(-5));
    check("stall_cycles_21", stall_21, 5);

    // engine returns H=60 with its flag clear on one pixel
    rot_mode = 3; ready_mode = 0;
    run_frame(A'(33));
    check("h60_reads", rd_count, S * S - 1);

    // randomized frames
    rot_mode = 2; fixed_delay = 0; ready_mode = 1;
    for (int f = 0; f < 4; f++) begin
      for (int a = 0; a < S * S; a++) mem[a] = P'($urandom);
      run_frame(A'(int'($urandom_range(0, 360)) - 180));
    end

    // ignored restart mid-frame, then reset in WAIT_ROT
    rot_mode = 0; fixed_delay = 3; ready_mode = 0;
    for (int a = 0; a < S * S; a++) mem[a] = P'(a);
    @(posedge clk); #1;
    angle = A'(45); exp_angle = A'(45); frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    angle = A'(-30); frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0; angle = '0;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.o_rot_start && pix_count >= 8) got = 1;
    end
    check("reached_mid_frame_request", got, 1);
    @(posedge clk); #1;
    check("in_wait_rot_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("reset_mid_frame_outputs", outs_vec(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("scoreboard_empty_after_reset", exp_q.size(), 0);
    run_frame(A'(7));

    // full-size address arithmetic: (59,59) -> 3599
    @(posedge clk); #1;
    angle_b = A'(12); fs_b = 1'b1;
    @(posedge clk); #1;
    fs_b = 1'b0;
    check("b_rot_start", busb.o_rot_start, 1);
    check("b_rot_coord", {busb.o_rot_H, busb.o_rot_V}, 0);
    @(posedge clk); #1;
    busb.i_rot_done = 1'b1; busb.i_rot_H = C'(59); busb.i_rot_V = C'(59);
    @(posedge clk); #1;
    busb.i_rot_done = 1'b0;
    check("b_mem_rd_en", busb.o_mem_rd_en, 1);
    check("b_mem_addr", busb.o_mem_addr, 3599);
    @(posedge clk); #1;
    busb.i_mem_rdata = 8'h3C;
    @(posedge clk); #1;
    check("b_pix_valid", busb.o_pix_valid, 1);
    check("b_pix_data", busb.o_pix_data, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
